dnn_block_sequencer: RTL and testbench

Block-cycle sequencer and result checker for the sparse DNN training datapath. It divides time into block cycles of `CPC` clocks and slices one full training case (activations and one-hot labels) into per-clock words for the network's input ports. It compares the network's per-clock actual outputs against the propagated ideal outputs and keeps per-case and running error statistics. It sits between the training-data store and the DNN core.

---
 rtl/dnn_block_sequencer.sv | 111 +++++++++++
 tb/tb_dnn_block_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/dnn_block_sequencer.sv
// dnn_block_sequencer
// Divides time into block cycles of CPC clocks, slices one training case into
// per-clock activation/label words, and grades the network's outputs against
// the propagated ideal outputs, keeping per-case and running statistics.
module dnn_block_sequencer #(
  parameter int CPC       = 18,
  parameter int WIDTH_IN  = 8,
  parameter int N_IN      = 1024,
  parameter int A_PER_CLK = 64,
  parameter int N_OUT     = 16,
  parameter int Y_PER_CLK = 1,
  parameter int CASES     = 50000,
  parameter int INIT_CASE = 0,
  localparam int CW = (CPC > 1) ? $clog2(CPC) : 1,
  localparam int IW = (CASES > 1) ? $clog2(CASES) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [WIDTH_IN*N_IN-1:0]        a_full,
  input  logic [N_OUT-1:0]                y_full,
  output logic [WIDTH_IN*A_PER_CLK-1:0]   a_in,
  output logic [Y_PER_CLK-1:0]            y_in,
  input  logic [Y_PER_CLK-1:0]            a_out,
  input  logic [Y_PER_CLK-1:0]            y_out,
  output logic [CW-1:0]                   count,
  output logic                            cycle_clk,
  output logic [IW-1:0]                   case_idx,
  output logic                            case_done,
  output logic                            case_error,
  output logic [31:0]                     num_cases,
  output logic [31:0]                     total_errors,
  output logic [31:0]                     epoch
);

  localparam int SW = ((CPC - 2) > 1) ? $clog2(CPC - 2) : 1;
  localparam int AW = WIDTH_IN * A_PER_CLK;
  localparam logic [CW-1:0] LAST_COUNT = CW'(CPC - 1);
  localparam logic [IW-1:0] LAST_CASE  = IW'(CASES - 1);

  logic [SW-1:0] sel;
  logic          is_last;
  logic          mismatch;
  logic          err_acc;
  logic          case_bad;

  // The first two clocks of a block carry the tail of the previous slice
  // (count-2 wraps), so only clocks from count 2 onward are graded.
  assign is_last   = (count == LAST_COUNT);
  assign cycle_clk = is_last;
  assign sel       = SW'(count - CW'(2));
  assign mismatch  = (count >= CW'(2)) && (a_out != y_out);
  assign case_bad  = err_acc | mismatch;

  // Slice the current case into the word for this clock; unused selector codes give zero
  always_comb begin
    a_in = '0;
    y_in = '0;
    if (int'(sel) < (CPC - 2)) begin
      a_in = a_full[int'(sel)*AW +: AW];
      y_in = y_full[int'(sel)*Y_PER_CLK +: Y_PER_CLK];
    end
  end

  // Position counter within the block cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= is_last ? '0 : count + CW'(1);
    end
  end

  // Sticky per-case error flag; the end-of-block clear takes priority over a new set
  always_ff @(posedge clk) begin
    if (reset) begin
      err_acc <= 1'b0;
    end else if (is_last) begin
      err_acc <= 1'b0;
    end else if (mismatch) begin
      err_acc <= 1'b1;
    end
  end

  // Case evaluation and running statistics at the end of each block
  always_ff @(posedge clk) begin
    if (reset) begin
      case_idx     <= IW'(INIT_CASE);
      case_done    <= 1'b0;
      case_error   <= 1'b0;
      num_cases    <= '0;
      total_errors <= '0;
      epoch        <= '0;
    end else begin
      case_done <= is_last;
      if (is_last) begin
        case_error <= case_bad;
        num_cases  <= num_cases + 32'd1;
        if (case_bad) begin
          total_errors <= total_errors + 32'd1;
        end
        if (case_idx == LAST_CASE) begin
          case_idx <= '0;
          epoch    <= epoch + 32'd1;
        end else begin
          case_idx <= case_idx + IW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dnn_block_sequencer.sv
// tb_dnn_block_sequencer
// Directed bench: a driver walks block cycles and queues the expected per-clock
// and per-case responses; an independent monitor grades whatever the DUT shows.
module tb_dnn_block_sequencer;

  logic          clk;
  logic          reset;
  logic [8191:0] a_full;
  logic [15:0]   y_full;
  logic [511:0]  a_in;
  logic [0:0]    y_in;
  logic [0:0]    a_out;
  logic [0:0]    y_out;
  logic [4:0]    count;
  logic          cycle_clk;
  logic [1:0]    case_idx;
  logic          case_done;
  logic          case_error;
  logic [31:0]   num_cases;
  logic [31:0]   total_errors;
  logic [31:0]   epoch;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int           cnt;
    bit           cyc;
    bit           done;
    logic [511:0] a;
    bit           y;
  } clk_exp_t;

  typedef struct {
    bit err;
    int num;
    int tot;
    int idx;
    int ep;
  } case_exp_t;

  clk_exp_t  clkQ[$];
  case_exp_t caseQ[$];

  dnn_block_sequencer #(
    .CPC(18), .WIDTH_IN(8), .N_IN(1024), .A_PER_CLK(64),
    .N_OUT(16), .Y_PER_CLK(1), .CASES(4), .INIT_CASE(3)
  ) dut (
    .clk(clk), .reset(reset), .a_full(a_full), .y_full(y_full),
    .a_in(a_in), .y_in(y_in), .a_out(a_out), .y_out(y_out),
    .count(count), .cycle_clk(cycle_clk), .case_idx(case_idx),
    .case_done(case_done), .case_error(case_error), .num_cases(num_cases),
    .total_errors(total_errors), .epoch(epoch)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Activation i holds i[7:0]; the slice for count c starts at activation sel*64
  function automatic logic [511:0] expA(input int c);
    logic [511:0] v;
    int s;
    s = (c >= 2) ? (c - 2) : (c + 14);
    for (int j = 0; j < 64; j++) v[8*j +: 8] = 8'(s * 64 + j);
    return v;
  endfunction

  task automatic pushCase(input bit err, input int num, input int tot, input int idx, input int ep);
    case_exp_t e;
    e.err = err; e.num = num; e.tot = tot; e.idx = idx; e.ep = ep;
    caseQ.push_back(e);
  endtask

  task automatic driveClock(input int c, input int mis, input bit doneExp);
    clk_exp_t e;
    a_out = 1'b0;
    y_out = (c == mis) ? 1'b1 : 1'b0;
    e.cnt  = c;
    e.cyc  = (c == 17);
    e.done = doneExp;
    e.a    = expA(c);
    e.y    = (c == 4);
    clkQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int mis, input bit first);
    for (int c = 0; c < 18; c++) driveClock(c, mis, (c == 0) && !first);
  endtask

  // Monitor: grade per-clock outputs and each case evaluation as they appear
  initial begin
    clk_exp_t  ce;
    case_exp_t ke;
    forever begin
      @(negedge clk);
      if (clkQ.size() > 0) begin
        ce = clkQ.pop_front();
        checkOutput("count", 512'(count), 512'(ce.cnt));
        checkOutput("cycle_clk", 512'(cycle_clk), 512'(ce.cyc));
        checkOutput("case_done", 512'(case_done), 512'(ce.done));
        checkOutput("a_in", a_in, ce.a);
        checkOutput("y_in", 512'(y_in), 512'(ce.y));
      end
      if (case_done === 1'b1) begin
        if (caseQ.size() > 0) begin
          ke = caseQ.pop_front();
          checkOutput("case_error", 512'(case_error), 512'(ke.err));
          checkOutput("num_cases", 512'(num_cases), 512'(ke.num));
          checkOutput("total_errors", 512'(total_errors), 512'(ke.tot));
          checkOutput("case_idx", 512'(case_idx), 512'(ke.idx));
          checkOutput("epoch", 512'(epoch), 512'(ke.ep));
        end else begin
          checkOutput("unexpected_case_done", 512'(case_done), 512'(0));
        end
      end
    end
  end

  // Driver: directed block sequence with hand-computed expectations
  initial begin
    reset  = 1'b1;
    a_out  = 1'b0;
    y_out  = 1'b0;
    y_full = 16'h0004;
    for (int i = 0; i < 1024; i++) a_full[8*i +: 8] = 8'(i);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_count", 512'(count), 512'(0));
    checkOutput("rst_case_idx", 512'(case_idx), 512'(3));
    checkOutput("rst_case_done", 512'(case_done), 512'(0));
    checkOutput("rst_case_error", 512'(case_error), 512'(0));
    checkOutput("rst_num_cases", 512'(num_cases), 512'(0));
    checkOutput("rst_total_errors", 512'(total_errors), 512'(0));
    checkOutput("rst_epoch", 512'(epoch), 512'(0));
    reset = 1'b0;

    pushCase(1'b0, 1, 0, 0, 1);
    applyStimulus(-1, 1'b1);
    pushCase(1'b0, 2, 0, 1, 1);
    applyStimulus(1, 1'b0);
    pushCase(1'b1, 3, 1, 2, 1);
    applyStimulus(17, 1'b0);
    pushCase(1'b1, 4, 2, 3, 1);
    applyStimulus(9, 1'b0);
    pushCase(1'b0, 5, 2, 0, 2);
    applyStimulus(0, 1'b0);

    for (int c = 0; c < 9; c++) driveClock(c, 5, c == 0);
    reset = 1'b1;
    driveClock(9, 5, 1'b0);
    checkOutput("midrst_count", 512'(count), 512'(0));
    checkOutput("midrst_num_cases", 512'(num_cases), 512'(0));
    checkOutput("midrst_total_errors", 512'(total_errors), 512'(0));
    checkOutput("midrst_case_idx", 512'(case_idx), 512'(3));
    checkOutput("midrst_epoch", 512'(epoch), 512'(0));
    checkOutput("midrst_case_error", 512'(case_error), 512'(0));
    reset = 1'b0;

    pushCase(1'b0, 1, 0, 0, 1);
    applyStimulus(-1, 1'b1);
    driveClock(0, -1, 1'b1);
    @(negedge clk);
    #1;
    checkOutput("case_queue_empty", 512'(caseQ.size()), 512'(0));
    checkOutput("clock_queue_empty", 512'(clkQ.size()), 512'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
